// File: rtl/pic_in_service_ctrl.sv
// PIC in-service register and rotating priority resolver with nested-interrupt gating and EOI handling.
// Optional auto-EOI acknowledge mode is enabled by defining PIC_IN_SERVICE_AUTO_EOI_EN.
module pic_in_service_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic               int_ack,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               rotate_on_eoi,
  input  logic               set_priority,
  input  logic [IDX_W-1:0]   priority_level,
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
  input  logic               auto_eoi,
`endif
  output logic [NUM_IRQ-1:0] isr,
  output logic               int_req,
  output logic [IDX_W-1:0]   int_vector,
  output logic               ack_valid,
  output logic [IDX_W-1:0]   ack_level,
  output logic               ack_spurious,
  output logic [IDX_W-1:0]   lowest_priority
);

  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_IRQ);
  localparam logic [IDX_W-1:0] SPUR_LVL = IDX_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]   lp_q, lp_d;
  logic               ack_valid_q, ack_valid_d;
  logic [IDX_W-1:0]   ack_level_q, ack_level_d;
  logic               ack_spur_q, ack_spur_d;

  logic [NUM_IRQ-1:0] pend;
  logic [IDX_W:0]     lvl;
  logic               win_found, top_found;
  logic [IDX_W-1:0]   win_idx, top_idx;
  logic [IDX_W:0]     win_rank, top_rank;
  logic               clr_vld;
  logic [IDX_W-1:0]   clr_idx;

  // Walk levels in rank order starting just above lowest_priority; first hit is highest ranked.
  always_comb begin
    pend      = irr & ~isr_q;
    lvl       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_rank  = '0;
    top_found = 1'b0;
    top_idx   = '0;
    top_rank  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      lvl = {1'b0, lp_q} + (IDX_W+1)'(i) + (IDX_W+1)'(1);
      if (lvl >= NUM_W) lvl = lvl - NUM_W;
      if (!win_found && pend[lvl[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = lvl[IDX_W-1:0];
        win_rank  = (IDX_W+1)'(i);
      end
      if (!top_found && isr_q[lvl[IDX_W-1:0]]) begin
        top_found = 1'b1;
        top_idx   = lvl[IDX_W-1:0];
        top_rank  = (IDX_W+1)'(i);
      end
    end
  end

  assign int_req    = win_found && (!top_found || (win_rank < top_rank));
  assign int_vector = int_req ? win_idx : '0;

  always_comb begin
    isr_d       = isr_q;
    lp_d        = lp_q;
    ack_valid_d = int_ack;
    ack_level_d = ack_level_q;
    ack_spur_d  = 1'b0;
    clr_vld     = 1'b0;
    clr_idx     = '0;

    if (eoi_specific) begin
      if ({1'b0, eoi_level} < NUM_W) begin
        clr_vld = 1'b1;
        clr_idx = eoi_level;
      end
    end else if (eoi_nonspecific && top_found) begin
      clr_vld = 1'b1;
      clr_idx = top_idx;
    end

    if (clr_vld) begin
      isr_d[clr_idx] = 1'b0;
      if (rotate_on_eoi) lp_d = clr_idx;
    end

    // Applied after the EOI clear so an ack on the same bit leaves it set.
    if (int_ack) begin
      if (int_req) begin
        ack_level_d = win_idx;
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
        if (auto_eoi) begin
          if (rotate_on_eoi) lp_d = win_idx;
        end else begin
          isr_d[win_idx] = 1'b1;
        end
`else
        isr_d[win_idx] = 1'b1;
`endif
      end else begin
        ack_spur_d  = 1'b1;
        ack_level_d = SPUR_LVL;
      end
    end

    if (set_priority && ({1'b0, priority_level} < NUM_W)) lp_d = priority_level;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q       <= '0;
      lp_q        <= SPUR_LVL;
      ack_valid_q <= 1'b0;
      ack_level_q <= '0;
      ack_spur_q  <= 1'b0;
    end else begin
      isr_q       <= isr_d;
      lp_q        <= lp_d;
      ack_valid_q <= ack_valid_d;
      ack_level_q <= ack_level_d;
      ack_spur_q  <= ack_spur_d;
    end
  end

  assign isr             = isr_q;
  assign lowest_priority = lp_q;
  assign ack_valid       = ack_valid_q;
  assign ack_level       = ack_level_q;
  assign ack_spurious    = ack_spur_q;

endmodule

// File: tb/tb_pic_in_service_ctrl.sv
// Scoreboard bench for pic_in_service_ctrl: rank-arithmetic reference model, directed plan then random traffic.
module tb_pic_in_service_ctrl;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irr = '0;
  logic       int_ack = 1'b0;
  logic       eoi_nonspecific = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = '0;
  logic       rotate_on_eoi = 1'b0;
  logic       set_priority = 1'b0;
  logic [2:0] priority_level = '0;
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
  logic       auto_eoi = 1'b0;
`endif
  logic [7:0] isr;
  logic       int_req;
  logic [2:0] int_vector;
  logic       ack_valid;
  logic [2:0] ack_level;
  logic       ack_spurious;
  logic [2:0] lowest_priority;

  always #5 clock = ~clock;

  pic_in_service_ctrl #(.NUM_IRQ(N), .IDX_W(3)) dut (
    .clock(clock), .reset(reset), .irr(irr), .int_ack(int_ack),
    .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority), .priority_level(priority_level),
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
    .auto_eoi(auto_eoi),
`endif
    .isr(isr), .int_req(int_req), .int_vector(int_vector), .ack_valid(ack_valid),
    .ack_level(ack_level), .ack_spurious(ack_spurious), .lowest_priority(lowest_priority)
  );

  typedef struct { int lvl; int spur; } ack_t;
  ack_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_isr;
  int         m_lp;
  bit         m_known = 1'b0;

  function automatic int rank_of(int lvl, int lp);
    return (lvl - lp - 1 + 2 * N) % N;
  endfunction

  function automatic int top_of(logic [7:0] v, int lp);
    int best = -1;
    for (int l = 0; l < N; l++)
      if (v[l] && (best < 0 || rank_of(l, lp) < rank_of(best, lp))) best = l;
    return best;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int         w, s, clr, n_lp;
    bit         req, auto_v;
    logic [7:0] n_isr;
    ack_t       a;
    @(negedge clock);
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
    auto_v = auto_eoi;
`else
    auto_v = 1'b0;
`endif
    w   = top_of(irr & ~m_isr, m_lp);
    s   = top_of(m_isr, m_lp);
    req = (w >= 0) && (s < 0 || rank_of(w, m_lp) < rank_of(s, m_lp));
    if (m_known) begin
      chk("int_req", int_req, req);
      chk("int_vector", int_vector, req ? w : 0);
      chk("isr", isr, m_isr);
      chk("lowest_priority", lowest_priority, m_lp);
    end
    n_isr = m_isr;
    n_lp  = m_lp;
    clr   = -1;
    if (eoi_specific) clr = eoi_level;
    else if (eoi_nonspecific && s >= 0) clr = s;
    if (clr >= 0) begin
      n_isr[clr] = 1'b0;
      if (rotate_on_eoi) n_lp = clr;
    end
    if (int_ack && req) begin
      if (auto_v) begin
        if (rotate_on_eoi) n_lp = w;
      end else begin
        n_isr[w] = 1'b1;
      end
    end
    if (set_priority) n_lp = priority_level;
    if (reset) begin
      n_isr = '0;
      n_lp  = N - 1;
    end else if (int_ack) begin
      a.lvl  = req ? w : N - 1;
      a.spur = req ? 0 : 1;
      exp_q.push_back(a);
    end
    @(posedge clock);
    #1;
    m_isr   = n_isr;
    m_lp    = n_lp;
    m_known = m_known || reset;
  endtask

  task automatic idle();
    int_ack = 0; eoi_nonspecific = 0; eoi_specific = 0; rotate_on_eoi = 0;
    set_priority = 0; reset = 0;
  endtask

  always @(negedge clock) begin
    ack_t e;
    if (ack_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ack_unexpected: got ack_valid=1 level %0d expected no ack (t=%0t)", ack_level, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ack_level", ack_level, e.lvl);
        chk("ack_spurious", ack_spurious, e.spur);
      end
    end
  end

  initial begin
    // Plan 1: reset with all requests pending.
    reset = 1; irr = 8'hFF;
    step();
    reset = 0;
    chk("tp1_isr", isr, 8'h00);
    chk("tp1_lp", lowest_priority, 7);
    chk("tp1_ack_valid", ack_valid, 0);
    #1;
    chk("tp1_int_req", int_req, 1);
    chk("tp1_int_vector", int_vector, 0);

    // Plan 2: ack and nesting.
    irr = 8'h24; int_ack = 1;
    step(); idle();
    chk("tp2_isr", isr, 8'h04);
    chk("tp2_ack_valid", ack_valid, 1);
    chk("tp2_ack_level", ack_level, 2);
    #1;
    chk("tp2_blocked", int_req, 0);
    irr = 8'h26; #1;
    chk("tp2_nest_req", int_req, 1);
    chk("tp2_nest_vec", int_vector, 1);
    int_ack = 1;
    step(); idle();
    chk("tp2_isr2", isr, 8'h06);

    // Plan 3: EOIs.
    eoi_nonspecific = 1;
    step(); idle();
    chk("tp3_ns", isr, 8'h04);
    eoi_specific = 1; eoi_level = 2;
    step(); idle();
    chk("tp3_sp", isr, 8'h00);
    eoi_nonspecific = 1;
    step(); idle();
    chk("tp3_ns_empty", isr, 8'h00);
    chk("tp3_lp", lowest_priority, 7);

    // Plan 4: rotation and explicit priority.
    irr = 8'h08; int_ack = 1;
    step(); idle();
    chk("tp4_isr", isr, 8'h08);
    irr = 8'h00; rotate_on_eoi = 1; eoi_nonspecific = 1;
    step(); idle();
    chk("tp4_isr_clr", isr, 8'h00);
    chk("tp4_lp", lowest_priority, 3);
    irr = 8'h11; #1;
    chk("tp4_vec", int_vector, 4);
    set_priority = 1; priority_level = 6; rotate_on_eoi = 1; eoi_specific = 1; eoi_level = 0;
    step(); idle();
    chk("tp4_setprio", lowest_priority, 6);

    // Plan 5: spurious ack, then ack colliding with EOI on the same level.
    irr = 8'h00; int_ack = 1;
    step(); idle();
    chk("tp5_spur", ack_spurious, 1);
    chk("tp5_spur_lvl", ack_level, 7);
    chk("tp5_isr", isr, 8'h00);
    irr = 8'h01; int_ack = 1; eoi_specific = 1; eoi_level = 0;
    step(); idle();
    chk("tp5_collide", isr[0], 1);

`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
    // Plan 6: auto-EOI acknowledges without entering service.
    reset = 1;
    step(); idle();
    auto_eoi = 1; irr = 8'h10; int_ack = 1;
    step(); idle();
    chk("tp6_level", ack_level, 4);
    chk("tp6_isr", isr, 8'h00);
    int_ack = 1; rotate_on_eoi = 1;
    step(); idle();
    chk("tp6_rot", lowest_priority, 4);
    auto_eoi = 0;
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      irr = 8'($urandom);
      if ($urandom_range(0, 99) < 40) irr = irr & 8'($urandom);
      int_ack         = ($urandom_range(0, 99) < 35);
      eoi_nonspecific = ($urandom_range(0, 99) < 20);
      eoi_specific    = ($urandom_range(0, 99) < 15);
      eoi_level       = 3'($urandom_range(0, 7));
      rotate_on_eoi   = ($urandom_range(0, 99) < 40);
      set_priority    = ($urandom_range(0, 99) < 6);
      priority_level  = 3'($urandom_range(0, 7));
      reset           = ($urandom_range(0, 199) == 0);
`ifdef PIC_IN_SERVICE_AUTO_EOI_EN
      auto_eoi        = ($urandom_range(0, 99) < 30);
`endif
      step();
    end
    idle();
    step();
    step();
    chk("ack_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
